// File: rtl/johnson_counter_param_if.sv
// ---------------------------------------------------------------------------
// johnson_counter_param_if
//
// Purpose: groups the control inputs and decoded outputs of
// johnson_counter_param. Clock and reset are not part of the bundle; they
// stay plain ports on the counter.
//
// Parameters:
//   WIDTH  number of counter stages (2..32)
//   PW     phase width, derived as $clog2(2*WIDTH); do not override
//
// Signals:
//   en        advance one step per clock when high
//   dir       0 = forward sequence, 1 = reverse sequence
//   load      synchronous load of load_val (wins over en)
//   load_val  value to load, may be an illegal state
//   dout      registered counter state
//   dout_bar  bitwise complement of dout
//   phase     decoded step index of dout (0 when illegal)
//   tc        next enabled step wraps the sequence
//   illegal   dout is not a legal state of the selected mode
//
// Modports:
//   master  drives the controls, observes the outputs (testbench / user)
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface johnson_counter_param_if #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2 * WIDTH)
) ();

  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_bar;
  logic [PW-1:0]    phase;
  logic             tc;
  logic             illegal;

  modport master (
    output en,
    output dir,
    output load,
    output load_val,
    input  dout,
    input  dout_bar,
    input  phase,
    input  tc,
    input  illegal
  );

  modport slave (
    input  en,
    input  dir,
    input  load,
    input  load_val,
    output dout,
    output dout_bar,
    output phase,
    output tc,
    output illegal
  );

endinterface

// File: rtl/johnson_counter_param.sv
// ---------------------------------------------------------------------------
// johnson_counter_param
//
// Purpose: parametrised twisted-ring (Johnson) or one-hot ring counter for
// phase and sequence generation. Supports run-time direction, enable and
// synchronous load, decodes the current step index and a terminal-count
// flag, and flags states that are not part of the selected sequence.
//
// Parameters:
//   WIDTH  number of stages, legal range 2..32
//   RING   0 = Johnson (period 2*WIDTH), 1 = one-hot ring (period WIDTH)
//   PW     phase width, derived as $clog2(2*WIDTH); do not override
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    johnson_counter_param_if.slave
//            in : en, dir, load, load_val
//            out: dout, dout_bar, phase, tc, illegal
//
// Optional feature (compile-time macro):
//   JOHNSON_SELF_CORRECT_EN
//     defined     : an illegal state (with load low) is replaced by the reset
//                   value on the next clock edge, ignoring en and dir
//     not defined : illegal states shift by the normal rules and are only
//                   left again by reset or load
// ---------------------------------------------------------------------------
module johnson_counter_param #(
  parameter int WIDTH = 4,
  parameter int RING  = 0,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  johnson_counter_param_if.slave bus
);

  // Sequence length of the selected mode and the phase that precedes a wrap
  // when counting forward.
  localparam int              PERIOD     = (RING != 0) ? WIDTH : 2 * WIDTH;
  localparam logic [PW-1:0]   LAST_PHASE = PW'(PERIOD - 1);

  // Johnson starts from all zeros; the ring starts with only the MSB set so
  // that its phase 0 is the MSB position.
  localparam logic [WIDTH-1:0] RESET_VAL =
    (RING != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] shift_val;
  logic [PW-1:0]    raw_phase;
  logic             legal;
  logic             illegal;
  logic [PW-1:0]    phase;

  // -------------------------------------------------------------------------
  // Mode-specific shift, legality check and phase decode. Only the logic of
  // the selected mode is elaborated.
  // -------------------------------------------------------------------------
  if (RING != 0) begin : g_ring

    // Forward rotates right, reverse rotates left; either way the single
    // set bit just travels around the register.
    always_comb begin
      if (bus.dir) begin
        shift_val = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
      end else begin
        shift_val = {state_q[0], state_q[WIDTH-1:1]};
      end
    end

    // A ring state is legal when exactly one bit is set: non-zero and
    // clearing the lowest set bit leaves nothing.
    assign legal = (state_q != '0) &&
                   ((state_q & (state_q - WIDTH'(1))) == '0);

    // The phase is the position of the set bit counted from the MSB. For a
    // legal state exactly one term contributes, so a plain OR of the
    // candidate indices is enough and stays a shallow tree. Illegal states
    // produce garbage here, which the output mux masks to zero.
    always_comb begin
      raw_phase = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (state_q[i]) begin
          raw_phase = raw_phase | PW'(WIDTH - 1 - i);
        end
      end
    end

  end else begin : g_johnson

    logic [WIDTH-2:0] upper_bits;
    logic [WIDTH-2:0] lower_bits;
    logic             msb_run;
    logic             lsb_run;
    logic [PW-1:0]    ones;
    logic [PW:0]      back_half;

    // Forward feeds the inverted LSB into the MSB; reverse feeds the
    // inverted MSB into the LSB, which retraces the forward sequence.
    always_comb begin
      if (bus.dir) begin
        shift_val = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
      end else begin
        shift_val = {~state_q[0], state_q[WIDTH-1:1]};
      end
    end

    // Neighbouring bit pairs: upper_bits[i] is the bit just above
    // lower_bits[i].
    assign upper_bits = state_q[WIDTH-1:1];
    assign lower_bits = state_q[WIDTH-2:0];

    // A run of ones anchored at the MSB means every set bit has a set bit
    // above it; a run anchored at the LSB means every set bit has a set bit
    // below it. All-zero and all-one satisfy both.
    assign msb_run = &(~lower_bits | upper_bits);
    assign lsb_run = &(~upper_bits | lower_bits);
    assign legal   = msb_run | lsb_run;

    // Population count; a synthesiser turns the chain into an adder tree.
    always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
        ones = ones + PW'(state_q[i]);
      end
    end

    // First half of the sequence fills ones in from the MSB, so the phase is
    // simply the number of ones. Second half drains them from the top, so
    // the phase is 2*WIDTH minus the remaining ones. One extra bit keeps
    // 2*WIDTH representable when it equals 2**PW.
    assign back_half = (PW + 1)'(2 * WIDTH) - {1'b0, ones};

    always_comb begin
      if (state_q[WIDTH-1]) begin
        raw_phase = ones;
      end else if (state_q == '0) begin
        raw_phase = '0;
      end else begin
        raw_phase = back_half[PW-1:0];
      end
    end

  end

  assign illegal = ~legal;

  // Illegal states never report a meaningful position.
  assign phase = illegal ? '0 : raw_phase;

  // -------------------------------------------------------------------------
  // Next-state selection. Load wins over everything so software can always
  // force a known value, even an illegal one for test purposes. When
  // self-correction is built in, an illegal state is replaced by the reset
  // value without looking at en or dir.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_q;
    if (bus.load) begin
      state_next = bus.load_val;
    end
`ifdef JOHNSON_SELF_CORRECT_EN
    else if (illegal) begin
      state_next = RESET_VAL;
    end
`endif
    else if (bus.en) begin
      state_next = shift_val;
    end
  end

  // -------------------------------------------------------------------------
  // The only state in the design. Reset clears asynchronously so the
  // outputs follow immediately; release is assumed synchronised upstream.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Terminal count looks ahead at the step that would happen on the
  // next edge: it is suppressed by load (no step happens) and by an illegal
  // state (there is no sequence to wrap).
  // -------------------------------------------------------------------------
  assign bus.dout     = state_q;
  assign bus.dout_bar = ~state_q;
  assign bus.phase    = phase;
  assign bus.illegal  = illegal;
  assign bus.tc       = bus.en & ~bus.load & legal &
                        (bus.dir ? (phase == '0) : (phase == LAST_PHASE));

endmodule
